// File: rtl/VX_gpu_pkg.sv
// Shared GPU definitions used by the tensor commit tracker.
//   hgmma_state_e : per-warp HGMMA_WAIT state (idle / waiting for drain)
//   cnt_width     : width of a per-warp in-flight counter for a given maximum
//   wid_width     : width of a warp index, never narrower than one bit
package VX_gpu_pkg;

  typedef enum logic {
    HGMMA_IDLE    = 1'b0,
    HGMMA_WAITING = 1'b1
  } hgmma_state_e;

  // Counter must hold 0..max_outstanding inclusive.
  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

  function automatic int wid_width(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

endpackage

// File: rtl/vx_tensor_warp_tracker.sv
// Per-warp HGMMA tracker: in-flight counter plus HGMMA_WAIT state machine.
//   clk, reset   : clock, asynchronous active-high reset
//   inc          : HGMMA accepted for this warp
//   dec          : ghost end-of-packet commit beat for this warp
//   wait_fire    : HGMMA_WAIT accepted for this warp
//   cnt          : registered in-flight HGMMA count
//   waiting      : warp is blocked on an HGMMA_WAIT
//   dec_ok       : decrement is legal (drives the scoreboard release)
//   underflow    : decrement arrived with nothing in flight
//   done         : HGMMA_WAIT satisfied this cycle (to the arbiter)
module vx_tensor_warp_tracker
  import VX_gpu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             wait_fire,
  output logic [CNT_W-1:0] cnt,
  output logic             waiting,
  output logic             dec_ok,
  output logic             underflow,
  output logic             done
);

  hgmma_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A same-cycle increment absorbs a decrement at count 0, so only a
  // decrement with nothing in flight and nothing arriving is an underflow.
  assign dec_ok    = dec && ((cnt_q != '0) || inc);
  assign underflow = dec && (cnt_q == '0) && !inc;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    cnt_d = cnt_q;
    unique case ({inc, dec_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      HGMMA_IDLE: begin
        if (wait_fire) begin
          if (cnt_d == '0) done    = 1'b1;
          else             state_d = HGMMA_WAITING;
        end
      end
      HGMMA_WAITING: begin
        // Issue is blocked while waiting, so the count only drains.
        if (cnt_d == '0) begin
          state_d = HGMMA_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = HGMMA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HGMMA_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its inputs from before the clock edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign waiting = (state_q == HGMMA_WAITING);

endmodule

// File: rtl/vx_tensor_commit_tracker.sv
// Tracks in-flight HGMMA instructions per warp, resolves HGMMA_WAIT, and
// turns tensor commit beats into scoreboard / pending-count pulses.
//   clk, reset                        : clock, asynchronous active-high reset
//   issue_valid/wid/is_wait, ready    : HGMMA / HGMMA_WAIT issue handshake
//   commit_valid/wid/tensor/eop/rd    : commit beats (never back-pressured)
//   commit_ready                      : high whenever not in reset
//   pending_decr_valid/wid            : non-ghost instruction completed
//   sb_release_valid/wid/rd           : ghost instruction completed, free rd
//   wait_done_valid/wid               : HGMMA_WAIT satisfied
//   outstanding                       : packed per-warp in-flight counts
//   underflow_err                     : sticky, ghost completion with count 0
// All pulse outputs are registered: one cycle after the causing fire.
module vx_tensor_commit_tracker
  import VX_gpu_pkg::*;
#(
  parameter int NUM_WARPS       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int NR_BITS         = 7,
  parameter int NW_W            = wid_width(NUM_WARPS),
  parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       issue_valid,
  input  logic [NW_W-1:0]            issue_wid,
  input  logic                       issue_is_wait,
  output logic                       issue_ready,

  input  logic                       commit_valid,
  input  logic [NW_W-1:0]            commit_wid,
  input  logic                       commit_tensor,
  input  logic                       commit_eop,
  input  logic [NR_BITS-1:0]         commit_rd,
  output logic                       commit_ready,

  output logic                       pending_decr_valid,
  output logic [NW_W-1:0]            pending_decr_wid,

  output logic                       sb_release_valid,
  output logic [NW_W-1:0]            sb_release_wid,
  output logic [NR_BITS-1:0]         sb_release_rd,

  output logic                       wait_done_valid,
  output logic [NW_W-1:0]            wait_done_wid,

  output logic [NUM_WARPS*CNT_W-1:0] outstanding,
  output logic                       underflow_err
);

  logic issue_fire, commit_fire;
  logic ghost_eop, plain_eop;

  logic [NUM_WARPS-1:0] warp_inc, warp_dec, warp_wait;
  logic [NUM_WARPS-1:0] warp_waiting, warp_dec_ok, warp_underflow, warp_done;
  logic [CNT_W-1:0]     warp_cnt [NUM_WARPS];

  logic                 sel_waiting, sel_full;

  logic [NUM_WARPS-1:0] wait_pend_q, wait_req, wait_grant;
  logic [NW_W-1:0]      grant_wid;
  logic                 grant_found;

  assign commit_ready = !reset;
  assign commit_fire  = commit_valid && commit_ready;
  assign issue_fire   = issue_valid && issue_ready;
  assign ghost_eop    = commit_fire && commit_tensor && commit_eop;
  assign plain_eop    = commit_fire && !commit_tensor && commit_eop;

  // Issue is refused for a warp parked on HGMMA_WAIT, or for an HGMMA on
  // a warp already at its in-flight limit; a WAIT is never refused for count.
  always_comb begin
    sel_waiting = 1'b0;
    sel_full    = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (issue_wid == NW_W'(w)) begin
        sel_waiting = warp_waiting[w];
        sel_full    = (warp_cnt[w] == CNT_W'(MAX_OUTSTANDING));
      end
    end
    issue_ready = !reset && !sel_waiting && (issue_is_wait || !sel_full);
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign warp_inc[w]  = issue_fire && !issue_is_wait && (issue_wid == NW_W'(w));
    assign warp_wait[w] = issue_fire &&  issue_is_wait && (issue_wid == NW_W'(w));
    assign warp_dec[w]  = ghost_eop && (commit_wid == NW_W'(w));

    vx_tensor_warp_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
    ) u_warp (
      .clk       (clk),
      .reset     (reset),
      .inc       (warp_inc[w]),
      .dec       (warp_dec[w]),
      .wait_fire (warp_wait[w]),
      .cnt       (warp_cnt[w]),
      .waiting   (warp_waiting[w]),
      .dec_ok    (warp_dec_ok[w]),
      .underflow (warp_underflow[w]),
      .done      (warp_done[w])
    );

    assign outstanding[w*CNT_W +: CNT_W] = warp_cnt[w];
  end

  // Only one wait_done can leave per cycle: the lowest requesting warp wins
  // and the rest stay pending for later cycles.
  always_comb begin
    wait_req    = wait_pend_q | warp_done;
    wait_grant  = '0;
    grant_wid   = '0;
    grant_found = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (wait_req[w] && !grant_found) begin
        grant_found   = 1'b1;
        wait_grant[w] = 1'b1;
        grant_wid     = NW_W'(w);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_decr_valid <= 1'b0;
      pending_decr_wid   <= '0;
      sb_release_valid   <= 1'b0;
      sb_release_wid     <= '0;
      sb_release_rd      <= '0;
      wait_done_valid    <= 1'b0;
      wait_done_wid      <= '0;
      wait_pend_q        <= '0;
      underflow_err      <= 1'b0;
    end else begin
      pending_decr_valid <= plain_eop;
      pending_decr_wid   <= plain_eop ? commit_wid : '0;

      // At most one warp sees a ghost beat per cycle, so any legal
      // decrement identifies the release.
      sb_release_valid   <= |warp_dec_ok;
      sb_release_wid     <= (|warp_dec_ok) ? commit_wid : '0;
      sb_release_rd      <= (|warp_dec_ok) ? commit_rd  : '0;

      wait_done_valid    <= grant_found;
      wait_done_wid      <= grant_wid;
      wait_pend_q        <= wait_req & ~wait_grant;

      underflow_err      <= underflow_err | (|warp_underflow);
    end
  end

endmodule

// File: tb/tb_vx_tensor_commit_tracker.sv
// Directed testbench for vx_tensor_commit_tracker with hand-computed
// expectations. Inputs change 2 ns after a rising edge; outputs are
// sampled at that point or 1 ns later for combinational ready.
module tb_vx_tensor_commit_tracker;

  localparam int NUM_WARPS       = 4;
  localparam int MAX_OUTSTANDING = 2;
  localparam int NR_BITS         = 7;
  localparam int NW_W            = 2;
  localparam int CNT_W           = 2;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       issue_valid;
  logic [NW_W-1:0]            issue_wid;
  logic                       issue_is_wait;
  logic                       issue_ready;
  logic                       commit_valid;
  logic [NW_W-1:0]            commit_wid;
  logic                       commit_tensor;
  logic                       commit_eop;
  logic [NR_BITS-1:0]         commit_rd;
  logic                       commit_ready;
  logic                       pending_decr_valid;
  logic [NW_W-1:0]            pending_decr_wid;
  logic                       sb_release_valid;
  logic [NW_W-1:0]            sb_release_wid;
  logic [NR_BITS-1:0]         sb_release_rd;
  logic                       wait_done_valid;
  logic [NW_W-1:0]            wait_done_wid;
  logic [NUM_WARPS*CNT_W-1:0] outstanding;
  logic                       underflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  vx_tensor_commit_tracker #(
    .NUM_WARPS       (NUM_WARPS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .NR_BITS         (NR_BITS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .issue_valid        (issue_valid),
    .issue_wid          (issue_wid),
    .issue_is_wait      (issue_is_wait),
    .issue_ready        (issue_ready),
    .commit_valid       (commit_valid),
    .commit_wid         (commit_wid),
    .commit_tensor      (commit_tensor),
    .commit_eop         (commit_eop),
    .commit_rd          (commit_rd),
    .commit_ready       (commit_ready),
    .pending_decr_valid (pending_decr_valid),
    .pending_decr_wid   (pending_decr_wid),
    .sb_release_valid   (sb_release_valid),
    .sb_release_wid     (sb_release_wid),
    .sb_release_rd      (sb_release_rd),
    .wait_done_valid    (wait_done_valid),
    .wait_done_wid      (wait_done_wid),
    .outstanding        (outstanding),
    .underflow_err      (underflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int w);
    return 32'(outstanding[w*CNT_W +: CNT_W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    issue_valid   = 1'b0;
    issue_wid     = '0;
    issue_is_wait = 1'b0;
    commit_valid  = 1'b0;
    commit_wid    = '0;
    commit_tensor = 1'b0;
    commit_eop    = 1'b0;
    commit_rd     = '0;
  endtask

  task automatic issue(input int wid, input logic is_wait);
    issue_valid   = 1'b1;
    issue_wid     = NW_W'(wid);
    issue_is_wait = is_wait;
  endtask

  task automatic commit(input int wid, input logic tensor, input logic eop, input int rd);
    commit_valid  = 1'b1;
    commit_wid    = NW_W'(wid);
    commit_tensor = tensor;
    commit_eop    = eop;
    commit_rd     = NR_BITS'(rd);
  endtask

  // Probe combinational issue_ready for a given request, then drop it.
  task automatic probe_ready(input string tag, input int wid, input logic is_wait, input logic exp);
    issue(wid, is_wait);
    #1;
    check(tag, 32'(issue_ready), 32'(exp));
    issue_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_sb"},   32'(sb_release_valid),   32'd0);
    check({tag, "_pd"},   32'(pending_decr_valid), 32'd0);
    check({tag, "_wd"},   32'(wait_done_valid),    32'd0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    issue_valid = 1'b1;
    #3;
    check("rst_issue_ready",  32'(issue_ready),  32'd0);
    check("rst_commit_ready", 32'(commit_ready), 32'd0);
    check("rst_outstanding",  32'(outstanding),  32'd0);
    check("rst_underflow",    32'(underflow_err), 32'd0);
    check_quiet("rst");
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("commit_ready", 32'(commit_ready), 32'd1);

    // Two HGMMAs on warp 0 fill it; a third is refused.
    tick();
    issue(0, 1'b0);
    #1;
    check("hg1_ready", 32'(issue_ready), 32'd1);
    tick();
    check("hg1_cnt", cnt_of(0), 32'd1);
    tick();
    check("hg2_cnt", cnt_of(0), 32'd2);
    #1;
    check("hg3_ready", 32'(issue_ready), 32'd0);
    idle();
    tick();
    check("hg3_cnt_held", cnt_of(0), 32'd2);

    // WAIT accepted at full count, warp 0 then blocks all issue.
    probe_ready("wait_ready_full", 0, 1'b1, 1'b1);
    issue(0, 1'b1);
    tick();
    idle();
    check_quiet("wait_enter");
    probe_ready("waiting_blocks_w0", 0, 1'b1, 1'b0);
    probe_ready("w1_not_blocked", 1, 1'b0, 1'b1);
    commit(0, 1'b1, 1'b1, 67);
    tick();
    idle();
    check("drain1_sb",     32'(sb_release_valid), 32'd1);
    check("drain1_rd",     32'(sb_release_rd),    32'd67);
    check("drain1_wid",    32'(sb_release_wid),   32'd0);
    check("drain1_cnt",    cnt_of(0),             32'd1);
    check("drain1_nodone", 32'(wait_done_valid),  32'd0);
    commit(0, 1'b1, 1'b1, 67);
    tick();
    idle();
    check("drain2_sb",      32'(sb_release_valid), 32'd1);
    check("drain2_rd",      32'(sb_release_rd),    32'd67);
    check("drain2_cnt",     cnt_of(0),             32'd0);
    check("drain2_done",    32'(wait_done_valid),  32'd1);
    check("drain2_done_wid", 32'(wait_done_wid),   32'd0);
    tick();
    check_quiet("drain_after");
    probe_ready("w0_idle_again", 0, 1'b0, 1'b1);

    // Same-warp increment and decrement cancel.
    issue(0, 1'b0);
    tick();
    idle();
    check("same_pre_cnt", cnt_of(0), 32'd1);
    issue(0, 1'b0);
    commit(0, 1'b1, 1'b1, 5);
    tick();
    idle();
    check("same_cnt", cnt_of(0), 32'd1);
    check("same_sb",  32'(sb_release_valid), 32'd1);
    check("same_rd",  32'(sb_release_rd),    32'd5);
    tick();
    check("same_one_pulse", 32'(sb_release_valid), 32'd0);
    commit(0, 1'b1, 1'b1, 5);
    tick();
    idle();
    check("same_drain_cnt", cnt_of(0), 32'd0);
    check("idle_drain_nodone", 32'(wait_done_valid), 32'd0);

    // Different-warp increment and decrement both apply.
    issue(2, 1'b0);
    tick();
    issue(3, 1'b0);
    commit(2, 1'b1, 1'b1, 11);
    tick();
    idle();
    check("diff_cnt2", cnt_of(2), 32'd0);
    check("diff_cnt3", cnt_of(3), 32'd1);
    check("diff_sb_wid", 32'(sb_release_wid), 32'd2);
    commit(3, 1'b1, 1'b1, 12);
    tick();
    idle();
    check("diff_drain_cnt3", cnt_of(3), 32'd0);

    // Non-ghost completion, then beats that must do nothing.
    commit(2, 1'b0, 1'b1, 20);
    tick();
    idle();
    check("pd_valid", 32'(pending_decr_valid), 32'd1);
    check("pd_wid",   32'(pending_decr_wid),   32'd2);
    check("pd_no_sb", 32'(sb_release_valid),   32'd0);
    commit(3, 1'b1, 1'b0, 21);
    tick();
    idle();
    check("pd_one_pulse", 32'(pending_decr_valid), 32'd0);
    check_quiet("ghost_noeop");
    check("ghost_noeop_cnt", cnt_of(3), 32'd0);
    check("ghost_noeop_uf",  32'(underflow_err), 32'd0);
    commit(1, 1'b0, 1'b0, 22);
    tick();
    idle();
    check_quiet("plain_noeop");

    // WAIT with nothing in flight completes immediately.
    issue(1, 1'b1);
    tick();
    idle();
    check("wait0_done",     32'(wait_done_valid), 32'd1);
    check("wait0_done_wid", 32'(wait_done_wid),   32'd1);
    tick();
    check("wait0_one_pulse", 32'(wait_done_valid), 32'd0);

    // Two warps complete together: warp 0 first, warp 1 next cycle.
    issue(1, 1'b0);
    tick();
    issue(1, 1'b1);
    tick();
    idle();
    probe_ready("w1_waiting", 1, 1'b0, 1'b0);
    issue(0, 1'b1);
    commit(1, 1'b1, 1'b1, 9);
    tick();
    idle();
    check("arb_first_valid", 32'(wait_done_valid), 32'd1);
    check("arb_first_wid",   32'(wait_done_wid),   32'd0);
    check("arb_sb_wid",      32'(sb_release_wid),  32'd1);
    check("arb_sb_rd",       32'(sb_release_rd),   32'd9);
    check("arb_cnt1",        cnt_of(1),            32'd0);
    tick();
    check("arb_second_valid", 32'(wait_done_valid), 32'd1);
    check("arb_second_wid",   32'(wait_done_wid),   32'd1);
    tick();
    check("arb_done_quiet", 32'(wait_done_valid), 32'd0);

    // Ghost completion on an empty warp: no release, sticky error.
    commit(1, 1'b1, 1'b1, 30);
    tick();
    idle();
    check("uf_no_sb", 32'(sb_release_valid), 32'd0);
    check("uf_flag",  32'(underflow_err),    32'd1);
    check("uf_cnt",   cnt_of(1),             32'd0);
    issue(2, 1'b0);
    tick();
    commit(2, 1'b1, 1'b1, 31);
    tick();
    idle();
    tick();
    check("uf_sticky", 32'(underflow_err), 32'd1);

    // Reset with warps 0 and 1 waiting and a release pulse on the outputs.
    issue(0, 1'b0);
    tick();
    tick();
    issue(1, 1'b0);
    tick();
    issue(0, 1'b1);
    tick();
    issue(1, 1'b1);
    tick();
    idle();
    probe_ready("pre_rst_w0_waiting", 0, 1'b1, 1'b0);
    commit(0, 1'b1, 1'b1, 3);
    tick();
    idle();
    check("pre_rst_sb", 32'(sb_release_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_sb",          32'(sb_release_valid), 32'd0);
    check("mid_rst_rd",          32'(sb_release_rd),    32'd0);
    check("mid_rst_outstanding", 32'(outstanding),      32'd0);
    check("mid_rst_underflow",   32'(underflow_err),    32'd0);
    check("mid_rst_commit_ready", 32'(commit_ready),    32'd0);
    check("mid_rst_issue_ready", 32'(issue_ready),      32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    probe_ready("post_rst_w0_idle", 0, 1'b0, 1'b1);
    probe_ready("post_rst_w1_idle", 1, 1'b0, 1'b1);
    tick();
    check("post_rst_outstanding", 32'(outstanding), 32'd0);
    check_quiet("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_tensor_commit_tracker.md
VX_TENSOR_COMMIT_TRACKER -- requirements
Module: vx_tensor_commit_tracker

Interface
REQ-001 Parameter NUM_WARPS, default 4, number of tracked warps; NW_W = max(1, clog2(NUM_WARPS)).
REQ-002 Parameter MAX_OUTSTANDING, default 2, maximum in-flight HGMMAs per warp; CNT_W = clog2(MAX_OUTSTANDING+1).
REQ-003 Parameter NR_BITS, default 7, register index width.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 issue_valid  input  1  HGMMA or HGMMA_WAIT presented by the issue stage.
REQ-007 issue_wid  input  NW_W  issuing warp.
REQ-008 issue_is_wait  input  1  1 = HGMMA_WAIT, 0 = HGMMA.
REQ-009 issue_ready  output  1  tracker accepts the issue this cycle.
REQ-010 commit_valid  input  1  commit beat from the tensor block.
REQ-011 commit_wid  input  NW_W  warp of the commit beat.
REQ-012 commit_tensor  input  1  1 = ghost (tensor writeback) beat.
REQ-013 commit_eop  input  1  last beat of its instruction.
REQ-014 commit_rd  input  NR_BITS  destination register of the beat.
REQ-015 commit_ready  output  1  tracker accepts the commit beat.
REQ-016 pending_decr_valid / pending_decr_wid  output  1 / NW_W  one-cycle pulse: decrement pending-instruction count of the warp.
REQ-017 sb_release_valid / sb_release_wid / sb_release_rd  output  1 / NW_W / NR_BITS  one-cycle pulse: clear scoreboard busy bit.
REQ-018 wait_done_valid / wait_done_wid  output  1 / NW_W  one-cycle pulse: HGMMA_WAIT of that warp satisfied.
REQ-019 outstanding  output  NUM_WARPS*CNT_W  per-warp in-flight HGMMA count.
REQ-020 underflow_err  output  1  sticky error flag.

Function
REQ-021 Issue fire = issue_valid && issue_ready; commit fire = commit_valid && commit_ready.
REQ-022 commit_ready SHALL be 1 whenever not in reset; the tracker never back-pressures commits.
REQ-023 issue_ready SHALL be 0 when warp issue_wid is in WAITING, or when issue_is_wait=0 and its count equals MAX_OUTSTANDING; otherwise 1 (combinational on issue_* and state).
REQ-024 HGMMA issue fire SHALL increment the warp count next cycle.
REQ-025 Ghost commit fire with eop=1 SHALL decrement the warp count next cycle and pulse sb_release with commit_wid/commit_rd next cycle; ghost beats with eop=0 SHALL produce no output and no count change.
REQ-026 Non-ghost commit fire with eop=1 SHALL pulse pending_decr next cycle; eop=0 SHALL produce nothing.
REQ-027 Same-cycle increment and decrement on the same warp SHALL leave the count unchanged; on different warps both apply.
REQ-028 Ghost eop commit to a warp with count 0 SHALL hold count at 0, emit no sb_release, and set underflow_err.
REQ-029 Per-warp FSM states IDLE, WAITING; reset state IDLE.
REQ-030 IDLE: WAIT fire with count 0 (after same-cycle decrement) -> stay IDLE, pulse wait_done next cycle; WAIT fire with count>0 -> WAITING.
REQ-031 WAITING: when the count becomes 0 -> IDLE with wait_done pulsed in the same cycle as the transition; no other exit.
REQ-032 At most one wait_done pulse per cycle; if multiple warps complete together, lowest wid first, others pulse in subsequent cycles (pending bit per warp).
REQ-033 All pulse outputs SHALL be registered: latency exactly one cycle from the causing fire.

Reset
REQ-034 Reset SHALL asynchronously clear all counts, FSMs to IDLE, pending wait bits, underflow_err, and every output to 0 (commit_ready and issue_ready included).
REQ-035 Reset mid-operation SHALL discard all in-flight tracking; no pulse is emitted for beats accepted in the reset-deasserting cycle's predecessor.

Structure
REQ-036 The HGMMA state enum (IDLE/WAITING) and CNT_W derivation SHALL reside in VX_gpu_pkg.
REQ-037 One sub-module vx_tensor_warp_tracker (per-warp counter + FSM) SHALL be instantiated NUM_WARPS times; top holds arbitration and output registers.

Verification
REQ-038 Issue 2 HGMMAs on warp 0 -> outstanding[0]=2, third HGMMA sees issue_ready=0.
REQ-039 Warp 0 count 2, WAIT issued -> WAITING; two ghost eop commits (rd=67) -> two sb_release pulses rd=67, wait_done wid 0 in the cycle count hits 0.
REQ-040 Count 1, HGMMA issue and ghost eop commit same cycle on warp 0 -> count stays 1, one sb_release pulse.
REQ-041 Ghost eop commit on warp 1 with count 0 -> no sb_release, underflow_err=1 and sticky until reset.
REQ-042 Non-ghost eop commit wid 2 -> pending_decr_valid=1 wid 2 one cycle later; ghost eop=0 beat -> no outputs.
REQ-043 Reset asserted with warps 0/1 WAITING -> all outputs 0 immediately, both warps IDLE, counts 0.
